// File: rtl/master.sv
// Single-byte I2C-style master: START, 7-bit address + R/W, ACK slot, one data byte, STOP.
// One bit spans two clk cycles; sclk toggles every clk while a byte or ACK is on the bus.
module master #(
  parameter logic [6:0] SLAVE_ADDR = 7'h2A
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       rw,
  input  logic [7:0] data_in,
  output logic [7:0] data_out,
  output logic [2:0] state,
  output logic       sclk,
  input  logic       sda_in,
  output logic       sda_out
);

  typedef enum logic [2:0] {
    StIdle  = 3'd0,
    StAddr  = 3'd1,
    StWait  = 3'd2,
    StRead  = 3'd3,
    StWrite = 3'd4,
    StDone  = 3'd5
  } state_e;

  state_e     r_state;
  state_e     w_state_d;
  logic [3:0] r_bit;
  logic [3:0] w_bit_d;
  logic       r_sclk;
  logic       w_sclk_d;
  logic       r_sda;
  logic       w_sda_d;
  logic       r_rw;
  logic       w_rw_d;
  logic [7:0] r_data;
  logic [7:0] w_data_d;
  logic [7:0] r_tx;
  logic [7:0] w_tx_d;
  logic [7:0] r_rx;
  logic [7:0] w_rx_d;
  logic       w_rise;

  // sclk is currently low, so this clk edge is the one that drives it high.
  assign w_rise = ~r_sclk;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= StIdle;
      r_bit   <= '0;
    end else begin
      r_state <= w_state_d;
      r_bit   <= w_bit_d;
    end
  end

  always_comb begin
    w_state_d = r_state;
    unique case (r_state)
      StIdle:  if (r_bit == 4'd1) w_state_d = StAddr;
      StAddr:  if (w_rise && r_bit == 4'd7) w_state_d = StWait;
      StWait: begin
        if (w_rise) begin
          if (sda_in)    w_state_d = StDone;
          else if (r_rw) w_state_d = StRead;
          else           w_state_d = StWrite;
        end
      end
      StRead:  if (w_rise && r_bit == 4'd8) w_state_d = StDone;
      StWrite: if (w_rise && r_bit == 4'd8) w_state_d = StDone;
      StDone:  w_state_d = StDone;
      default: w_state_d = StIdle;
    endcase
  end

  // Bit counter restarts on every state change and advances on each sclk rise.
  always_comb begin
    w_bit_d = r_bit;
    if (w_state_d != r_state) begin
      w_bit_d = '0;
    end else begin
      unique case (r_state)
        StIdle:                      w_bit_d = 4'd1;
        StAddr, StWait, StRead, StWrite: begin
          if (w_rise) w_bit_d = r_bit + 4'd1;
        end
        StDone:  if (r_bit < 4'd2) w_bit_d = r_bit + 4'd1;
        default: w_bit_d = '0;
      endcase
    end
  end

  always_comb begin
    w_sclk_d = r_sclk;
    w_sda_d  = r_sda;
    w_rw_d   = r_rw;
    w_data_d = r_data;
    w_tx_d   = r_tx;
    w_rx_d   = r_rx;
    unique case (r_state)
      StIdle: begin
        w_sclk_d = 1'b1;
        w_sda_d  = 1'b1;
        if (r_bit == 4'd1) begin
          w_sda_d  = 1'b0;
          w_rw_d   = rw;
          w_data_d = data_in;
          w_tx_d   = {SLAVE_ADDR, rw};
        end
      end
      StAddr: begin
        w_sclk_d = ~r_sclk;
        if (w_rise) w_tx_d  = {r_tx[6:0], 1'b0};
        else        w_sda_d = r_tx[7];
      end
      StWait: begin
        w_sclk_d = ~r_sclk;
        if (w_rise) w_tx_d  = r_data;
        else        w_sda_d = 1'b1;
      end
      StRead: begin
        w_sclk_d = ~r_sclk;
        if (!w_rise)               w_sda_d = 1'b1;
        else if (r_bit < 4'd8)     w_rx_d  = {r_rx[6:0], sda_in};
      end
      StWrite: begin
        w_sclk_d = ~r_sclk;
        if (w_rise)                w_tx_d  = {r_tx[6:0], 1'b0};
        else if (r_bit < 4'd8)     w_sda_d = r_tx[7];
        else                       w_sda_d = 1'b1;
      end
      StDone: begin
        // Pull SDA low for one clk with SCLK high, then release it: the STOP edge.
        w_sclk_d = 1'b1;
        w_sda_d  = (r_bit != 4'd0);
      end
      default: begin
        w_sclk_d = 1'b1;
        w_sda_d  = 1'b1;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_sclk <= 1'b1;
      r_sda  <= 1'b1;
      r_rw   <= 1'b0;
      r_data <= '0;
      r_tx   <= '0;
      r_rx   <= '0;
    end else begin
      r_sclk <= w_sclk_d;
      r_sda  <= w_sda_d;
      r_rw   <= w_rw_d;
      r_data <= w_data_d;
      r_tx   <= w_tx_d;
      r_rx   <= w_rx_d;
    end
  end

  assign state    = r_state;
  assign sclk     = r_sclk;
  assign sda_out  = r_sda;
  assign data_out = r_rx;

endmodule

// File: tb/tb_master.sv
// Directed bench for the I2C master: reset, addressing, read, write, NACK, STOP, async reset.
module tb_master;

  logic       clk = 1'b0;
  logic       rst;
  logic       rw;
  logic       sda_in;
  logic [7:0] data_in;
  logic [7:0] data_out;
  logic [2:0] state;
  logic       sclk;
  logic       sda_out;
  logic       prev_sclk;
  logic [2:0] prev_state;
  int         checks = 0;
  int         errors = 0;

  master #(.SLAVE_ADDR(7'h2A)) dut (
    .clk      (clk),
    .rst      (rst),
    .rw       (rw),
    .data_in  (data_in),
    .data_out (data_out),
    .state    (state),
    .sclk     (sclk),
    .sda_in   (sda_in),
    .sda_out  (sda_out)
  );

  always #5 clk = ~clk;

  task automatic step();
    prev_sclk  = sclk;
    prev_state = state;
    @(negedge clk);
  endtask

  task automatic start_xfer(input logic r, input logic [7:0] d);
    rst     = 1'b1;
    rw      = r;
    data_in = d;
    sda_in  = 1'b1;
    @(negedge clk);
    rst        = 1'b0;
    prev_sclk  = sclk;
    prev_state = state;
  endtask

  task automatic test_reset();
    rst = 1'b0; rw = 1'b1; data_in = 8'h00; sda_in = 1'b1;
    #1 rst = 1'b1;
    #1;
    checks++;
    if (state !== 3'd0) begin errors++; $display("FAIL reset_state got %0d want 0", state); end
    checks++;
    if (sclk !== 1'b1) begin errors++; $display("FAIL reset_sclk got %b want 1", sclk); end
    checks++;
    if (sda_out !== 1'b1) begin errors++; $display("FAIL reset_sda got %b want 1", sda_out); end
    checks++;
    if (data_out !== 8'h00) begin errors++; $display("FAIL reset_dout got %h want 00", data_out); end
    @(negedge clk);
    rst = 1'b0;
    step();
    checks++;
    if ({state, sclk, sda_out} !== {3'd0, 1'b1, 1'b1}) begin
      errors++; $display("FAIL idle_hold got st=%0d scl=%b sda=%b want 0 1 1", state, sclk, sda_out);
    end
    step();
    checks++;
    if ({state, sclk, sda_out} !== {3'd1, 1'b1, 1'b0}) begin
      errors++; $display("FAIL start_cond got st=%0d scl=%b sda=%b want 1 1 0", state, sclk, sda_out);
    end
  endtask

  task automatic test_addressing();
    int         cyc;
    int         k;
    logic [7:0] bits;
    start_xfer(1'b1, 8'h00);
    cyc = 0;
    while (state !== 3'd1 && cyc < 10) begin step(); cyc++; end
    checks++;
    if ({state, sclk, sda_out} !== {3'd1, 1'b1, 1'b0}) begin
      errors++; $display("FAIL addr_start got st=%0d scl=%b sda=%b want 1 1 0", state, sclk, sda_out);
    end
    bits = '0; k = 0; cyc = 0;
    while (k < 8 && cyc < 40) begin
      step(); cyc++;
      if (!prev_sclk && sclk) begin bits[7-k] = sda_out; k++; end
    end
    checks++;
    if (bits !== 8'h55) begin errors++; $display("FAIL addr_bits got %h want 55", bits); end
    checks++;
    if (cyc != 16) begin errors++; $display("FAIL addr_len got %0d want 16", cyc); end
    checks++;
    if (state !== 3'd2) begin errors++; $display("FAIL addr_to_wait got %0d want 2", state); end
  endtask

  task automatic test_read();
    logic [7:0]  rbyte;
    logic [2:0]  last;
    logic [11:0] seq;
    int          n;
    int          k;
    int          cyc;
    rbyte = 8'hF6;
    start_xfer(1'b1, 8'h00);
    last = state; seq = '0; n = 0; k = 0; cyc = 0;
    while (state !== 3'd5 && cyc < 200) begin
      step(); cyc++;
      if (!prev_sclk && sclk && prev_state == 3'd3) k++;
      if (state !== last) begin
        if (n < 4) seq = {seq[8:0], state};
        n++;
        last = state;
      end
      if (!sclk) begin
        if (state == 3'd2)      sda_in = 1'b0;
        else if (state == 3'd3) sda_in = (k < 8) ? rbyte[7-k] : 1'b1;
      end
    end
    sda_in = 1'b1;
    checks++;
    if (n != 4) begin errors++; $display("FAIL read_nstates got %0d want 4", n); end
    checks++;
    if (seq !== {3'd1, 3'd2, 3'd3, 3'd5}) begin
      errors++; $display("FAIL read_seq got %o want 1235", seq);
    end
    checks++;
    if (data_out !== 8'hF6) begin errors++; $display("FAIL read_data got %h want f6", data_out); end
    checks++;
    if (k != 9) begin errors++; $display("FAIL read_rises got %0d want 9", k); end
  endtask

  task automatic test_reset_done();
    @(negedge clk);
    #2 rst = 1'b1;
    #1;
    checks++;
    if ({state, data_out} !== {3'd0, 8'h00}) begin
      errors++; $display("FAIL reset_dout_clear got st=%0d dout=%h want 0 00", state, data_out);
    end
  endtask

  task automatic test_write();
    logic [7:0] bits;
    logic       ack;
    int         k;
    int         cyc;
    start_xfer(1'b0, 8'hA5);
    bits = '0; ack = 1'b0; k = 0; cyc = 0;
    while (state !== 3'd5 && cyc < 200) begin
      step(); cyc++;
      if (!prev_sclk && sclk && prev_state == 3'd4) begin
        if (k < 8) bits[7-k] = sda_out;
        else       ack = sda_out;
        k++;
      end
      if (!sclk) begin
        if (state == 3'd2)      sda_in = 1'b0;
        else if (state == 3'd4) sda_in = 1'b1;
      end
    end
    sda_in = 1'b1;
    checks++;
    if (bits !== 8'hA5) begin errors++; $display("FAIL write_bits got %h want a5", bits); end
    checks++;
    if (ack !== 1'b1) begin errors++; $display("FAIL write_ack_release got %b want 1", ack); end
    checks++;
    if (k != 9) begin errors++; $display("FAIL write_rises got %0d want 9", k); end
    checks++;
    if (state !== 3'd5) begin errors++; $display("FAIL write_done got %0d want 5", state); end
    checks++;
    if (data_out !== 8'h00) begin errors++; $display("FAIL write_dout got %h want 00", data_out); end
  endtask

  task automatic test_nack();
    logic [2:0] last;
    logic [8:0] seq;
    int         n;
    int         cyc;
    start_xfer(1'b1, 8'h00);
    last = state; seq = '0; n = 0; cyc = 0;
    while (state !== 3'd5 && cyc < 200) begin
      step(); cyc++;
      if (state !== last) begin
        if (n < 3) seq = {seq[5:0], state};
        n++;
        last = state;
      end
    end
    checks++;
    if (n != 3 || seq !== {3'd1, 3'd2, 3'd5}) begin
      errors++; $display("FAIL nack_seq got n=%0d seq=%o want n=3 seq=125", n, seq);
    end
    checks++;
    if (data_out !== 8'h00) begin errors++; $display("FAIL nack_dout got %h want 00", data_out); end
  endtask

  task automatic test_stop();
    int   bad;
    logic saw_low;
    logic saw_rise;
    logic psda;
    bad = 0; saw_low = 1'b0; saw_rise = 1'b0;
    for (int i = 0; i < 12; i++) begin
      psda = sda_out;
      step();
      if (!sclk) bad++;
      if (sclk && !sda_out) saw_low = 1'b1;
      if (saw_low && sclk && !psda && sda_out) saw_rise = 1'b1;
    end
    checks++;
    if (bad != 0) begin errors++; $display("FAIL stop_sclk_low got %0d want 0", bad); end
    checks++;
    if (saw_low !== 1'b1) begin errors++; $display("FAIL stop_sda_low got %b want 1", saw_low); end
    checks++;
    if (saw_rise !== 1'b1) begin errors++; $display("FAIL stop_sda_rise got %b want 1", saw_rise); end
    checks++;
    if ({state, sclk, sda_out} !== {3'd5, 1'b1, 1'b1}) begin
      errors++; $display("FAIL stop_hold got st=%0d scl=%b sda=%b want 5 1 1", state, sclk, sda_out);
    end
  endtask

  task automatic test_reset_mid();
    start_xfer(1'b1, 8'h00);
    for (int i = 0; i < 7; i++) step();
    checks++;
    if ({state, sclk, sda_out} !== {3'd1, 1'b0, 1'b0}) begin
      errors++; $display("FAIL mid_pre got st=%0d scl=%b sda=%b want 1 0 0", state, sclk, sda_out);
    end
    #2 rst = 1'b1;
    #1;
    checks++;
    if ({state, sclk, sda_out, data_out} !== {3'd0, 1'b1, 1'b1, 8'h00}) begin
      errors++;
      $display("FAIL mid_reset got st=%0d scl=%b sda=%b dout=%h want 0 1 1 00",
               state, sclk, sda_out, data_out);
    end
    @(negedge clk);
    rst = 1'b0;
  endtask

  initial begin
    test_reset();
    test_addressing();
    test_read();
    test_reset_done();
    test_write();
    test_nack();
    test_stop();
    test_reset_mid();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/master.md
MASTER -- requirements
Module: master

Interface
REQ-001 SHALL have parameter SLAVE_ADDR, default 7'h2A: 7-bit target address sent MSB first.
REQ-002 SHALL have port clk, input, 1: single system clock; all logic on rising edge.
REQ-003 SHALL have port rst, input, 1: reset, asynchronous, active-high.
REQ-004 SHALL have port rw, input, 1: 1 = read transfer, 0 = write transfer; sampled when leaving IDLE.
REQ-005 SHALL have port data_in, input, 8: byte to transmit in a write transfer; sampled when leaving IDLE.
REQ-006 SHALL have port data_out, output, 8: byte received in a read transfer.
REQ-007 SHALL have port state, output, 3: current FSM state code.
REQ-008 SHALL have port sclk, output, 1: I2C clock.
REQ-009 SHALL have port sda_in, input, 1: sampled SDA line from the bus.
REQ-010 SHALL have port sda_out, output, 1: SDA drive; 1 = released/high, 0 = pull low.

Function
REQ-011 SHALL encode states as IDLE=0, ADDRESSING=1, WAITING=2, READING=3, WRITING=4, DONE=5; codes 6 and 7 SHALL go to IDLE on the next clk.
REQ-012 SHALL toggle sclk on every clk edge in ADDRESSING, WAITING, READING and WRITING, giving bit period = 2 clk (low half, then high half).
REQ-013 SHALL change sda_out only on the clk edge that drives sclk low, except for START and STOP.
REQ-014 SHALL sample sda_in only on the clk edge that drives sclk high.
REQ-015 IDLE: SHALL hold sclk=1 and sda_out=1 for one clk after reset release, then drive sda_out=0 with sclk=1 (START), latch rw and data_in, and enter ADDRESSING.
REQ-016 ADDRESSING: SHALL send 8 bits, MSB first: SLAVE_ADDR[6:0] then the latched rw; it SHALL take 16 clk, then enter WAITING.
REQ-017 WAITING: SHALL release sda_out=1 for one sclk pulse and sample sda_in at sclk rise.
REQ-018 WAITING SHALL then go: sda_in=0 (ACK) and rw=1 -> READING; ACK and rw=0 -> WRITING; sda_in=1 (NACK) -> DONE.
REQ-019 READING: SHALL hold sda_out=1 and shift 8 sda_in samples MSB first into data_out.
REQ-020 READING: data_out SHALL be complete after the 8th sclk rise; the master SHALL then drive one NACK bit (sda_out=1 for one sclk pulse) and enter DONE.
REQ-021 WRITING: SHALL shift the latched data_in MSB first onto sda_out over 8 bits, then release sda_out for one ACK sclk pulse (sda_in ignored) and enter DONE.
REQ-022 DONE: SHALL drive sclk=1 with sda_out 0 for one clk, then sda_out=1 (STOP), and stay in DONE with both lines high until reset.
REQ-023 SHALL leave data_out unchanged in all states except READING.
REQ-024 SHALL use an internal bit counter 0..8 that restarts at 0 on every state change.

Reset
REQ-025 On rst=1, at any time including mid-transfer, SHALL immediately set state=IDLE, sclk=1, sda_out=1, data_out=8'h00 and clear the counters.
REQ-026 After rst deasserts, SHALL start a new transfer per REQ-015.

Verification
REQ-027 Reset: rst pulse mid-ADDRESSING -> state=0, sclk=1, sda_out=1, data_out=0 immediately, without waiting for a clk edge.
REQ-028 Addressing: rw=1 -> sda_out falls while sclk=1, then at the 8 sclk rises sda_out = 0,1,0,1,0,1,0,1 (7'h2A + R), then state=2.
REQ-029 Read: bench drives ACK, then bits of 8'hF6 MSB first while sclk is low -> state sequence 1,2,3,5 and data_out=8'hF6 when in DONE.
REQ-030 Write: rw=0, data_in=8'hA5, bench drives ACK -> after the address, sda_out at sclk rises = 1,0,1,0,0,1,0,1, then state=5.
REQ-031 NACK: sda_in held 1 in WAITING -> state goes from 2 to 5 and data_out stays 8'h00.
REQ-032 STOP: in DONE, sda_out rises while sclk=1, and both lines stay high until reset.
